scandoubler_framing: RTL and testbench

- Generates the framing signals consumed by the scandoubler line-double datapath: write address `hcnt`, read address `sd_hcnt`, buffer bank select `line_toggle` and doubled horizontal sync `hs_sd`.
- Measures incoming line length and hsync width in `pe_in` ticks, then replays each line twice at the `pe_out` rate.
- Sits between the core's raw video timing and the line buffer, one instance per scandoubler.

---
 rtl/scandoubler_pkg.sv | 15 +
 rtl/scandoubler_outtiming.sv | 60 ++++++
 rtl/scandoubler_framing.sv | 118 +++++++++++
 tb/tb_scandoubler_framing.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/scandoubler_pkg.sv
// rtl/scandoubler_pkg.sv - shared state encoding and address saturation helper for the scandoubler framing block
package scandoubler_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } sd_state_t;

    // Largest line-buffer address for a given address width (HCNT_MAX = 2**width-1)
    function automatic int unsigned hcnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/scandoubler_outtiming.sv
// rtl/scandoubler_outtiming.sv - pe_out-rate read address and doubled hsync generator
module scandoubler_outtiming
    import scandoubler_pkg::*;
#(
    parameter int HCNT_WIDTH  = 10,
    parameter int HSCNT_WIDTH = 12
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   pe_out,
    input  logic                   locked,
    input  logic                   restart_pend,
    input  logic [HSCNT_WIDTH-1:0] line_len,
    input  logic [HSCNT_WIDTH-1:0] hs_len,
    output logic [HCNT_WIDTH-1:0]  sd_hcnt,
    output logic                   hs_sd,
    output logic                   pend_clr
);

    localparam logic [HCNT_WIDTH-1:0] SD_MAX = HCNT_WIDTH'(hcnt_max(HCNT_WIDTH));

    logic [HCNT_WIDTH-1:0]  sd_next;
    logic [HSCNT_WIDTH-1:0] sd_wide;
    logic [HSCNT_WIDTH-1:0] hs_half;

    // Wrap compare is done at full counter width so a line longer than the
    // buffer never matches and the read address just parks at the top
    assign sd_wide  = HSCNT_WIDTH'(sd_hcnt);
    assign hs_half  = hs_len >> 1;
    assign pend_clr = pe_out & locked & restart_pend;

    // Next read address: restart beats wrap, wrap beats increment
    always_comb begin
        sd_next = sd_hcnt;
        if (restart_pend) begin
            sd_next = '0;
        end else if (sd_wide == line_len - HSCNT_WIDTH'(1)) begin
            sd_next = '0;
        end else if (sd_hcnt != SD_MAX) begin
            sd_next = sd_hcnt + HCNT_WIDTH'(1);
        end
    end

    // Output line replay; held idle whenever no valid line length is held
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sd_hcnt <= '0;
            hs_sd   <= 1'b0;
        end else if (pe_out) begin
            if (!locked) begin
                sd_hcnt <= '0;
                hs_sd   <= 1'b0;
            end else begin
                sd_hcnt <= sd_next;
                hs_sd   <= (HSCNT_WIDTH'(sd_next) < hs_half);
            end
        end
    end

endmodule

// File: rtl/scandoubler_framing.sv
// rtl/scandoubler_framing.sv - input line measurement and framing for the scandoubler line buffer
module scandoubler_framing
    import scandoubler_pkg::*;
#(
    parameter int HCNT_WIDTH  = 10,
    parameter int HSCNT_WIDTH = 12
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  pe_in,
    input  logic                  pe_out,
    input  logic                  hs_in,
    output logic [HCNT_WIDTH-1:0] hcnt,
    output logic [HCNT_WIDTH-1:0] sd_hcnt,
    output logic                  line_toggle,
    output logic                  hs_sd,
    output logic                  locked
);

    localparam logic [HSCNT_WIDTH-1:0] PCNT_MAX   = '1;
    localparam logic [HSCNT_WIDTH-1:0] HCNT_MAX_W = HSCNT_WIDTH'(hcnt_max(HCNT_WIDTH));

    sd_state_t              state_q, state_d;
    logic                   hs_prev;
    logic                   rise, fall;
    logic [HSCNT_WIDTH-1:0] pcnt, pcnt_next, len_capture;
    logic [HSCNT_WIDTH-1:0] line_len, hs_len;
    logic [HCNT_WIDTH-1:0]  hcnt_next;
    logic                   restart_pend, pend_clr;

    assign rise   = hs_in & ~hs_prev;
    assign fall   = ~hs_in & hs_prev;
    assign locked = (state_q == LOCKED);

    // A measured length saturates rather than wrapping to zero
    assign len_capture = (pcnt == PCNT_MAX) ? PCNT_MAX : pcnt + HSCNT_WIDTH'(1);

    // Write address follows the pixel count but sticks at the top of the buffer
    assign hcnt_next = (pcnt_next > HCNT_MAX_W) ? HCNT_MAX_W[HCNT_WIDTH-1:0]
                                                : pcnt_next[HCNT_WIDTH-1:0];

    // Next pixel count: restart on hsync rise, otherwise count up and saturate
    always_comb begin
        pcnt_next = pcnt;
        if (rise) begin
            pcnt_next = '0;
        end else if (pcnt != PCNT_MAX) begin
            pcnt_next = pcnt + HSCNT_WIDTH'(1);
        end
    end

    // Lock state: two rises to lock, an endless line drops back to searching
    always_comb begin
        state_d = state_q;
        if (pe_in) begin
            case (state_q)
                SEARCH:  if (rise) state_d = MEASURE;
                MEASURE: begin
                    if (rise) state_d = LOCKED;
                    else if (pcnt == PCNT_MAX) state_d = SEARCH;
                end
                LOCKED:  if (!rise && pcnt == PCNT_MAX) state_d = SEARCH;
                default: state_d = SEARCH;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) state_q <= SEARCH;
        else       state_q <= state_d;
    end

    // Input-rate measurement of line length and hsync width
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_prev     <= 1'b0;
            pcnt        <= '0;
            hcnt        <= '0;
            line_toggle <= 1'b0;
            line_len    <= '0;
            hs_len      <= '0;
        end else if (pe_in) begin
            hs_prev <= hs_in;
            pcnt    <= pcnt_next;
            hcnt    <= hcnt_next;
            if (rise) begin
                line_toggle <= ~line_toggle;
                if (state_q != SEARCH) line_len <= len_capture;
            end
            if (fall) hs_len <= len_capture;
        end
    end

    // Restart request handed to the output side; a new rise wins over consumption
    always_ff @(posedge clk_sys) begin
        if (reset)               restart_pend <= 1'b0;
        else if (pe_in && rise)  restart_pend <= 1'b1;
        else if (pend_clr)       restart_pend <= 1'b0;
    end

    scandoubler_outtiming #(
        .HCNT_WIDTH  (HCNT_WIDTH),
        .HSCNT_WIDTH (HSCNT_WIDTH)
    ) u_outtiming (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .pe_out       (pe_out),
        .locked       (locked),
        .restart_pend (restart_pend),
        .line_len     (line_len),
        .hs_len       (hs_len),
        .sd_hcnt      (sd_hcnt),
        .hs_sd        (hs_sd),
        .pend_clr     (pend_clr)
    );

endmodule

// File: tb/tb_scandoubler_framing.sv
// tb/tb_scandoubler_framing.sv - directed self-checking bench for scandoubler_framing
module tb_scandoubler_framing;

    logic       clk_sys, reset, pe_in, pe_out, hs_in;
    logic [9:0] hcnt, sd_hcnt;
    logic [5:0] hcnt6, sd_hcnt6;
    logic       line_toggle, hs_sd, locked;
    logic       line_toggle6, hs_sd6, locked6;

    int n_pass = 0;
    int n_total = 0;
    int line_px = 100;
    int hs_w = 8;
    bit gen_en = 0;
    int cyc, px;

    typedef struct {
        int off;
        int hcnt;
        int sd;
        int hs;
        int hcnt6;
        int sd6;
        int hs6;
    } vec_t;

    vec_t tbl[12];

    scandoubler_framing u_dut (
        .clk_sys(clk_sys), .reset(reset), .pe_in(pe_in), .pe_out(pe_out), .hs_in(hs_in),
        .hcnt(hcnt), .sd_hcnt(sd_hcnt), .line_toggle(line_toggle), .hs_sd(hs_sd), .locked(locked)
    );

    scandoubler_framing #(.HCNT_WIDTH(6), .HSCNT_WIDTH(12)) u_dut6 (
        .clk_sys(clk_sys), .reset(reset), .pe_in(pe_in), .pe_out(pe_out), .hs_in(hs_in),
        .hcnt(hcnt6), .sd_hcnt(sd_hcnt6), .line_toggle(line_toggle6), .hs_sd(hs_sd6), .locked(locked6)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Video source: pe_in every 4 clks, pe_out every 2, hsync at the start of each line
    initial begin
        cyc = 0; px = 0; pe_in = 1'b0; pe_out = 1'b0; hs_in = 1'b0;
        forever begin
            @(negedge clk_sys);
            cyc++;
            pe_out = (cyc % 2 == 0);
            pe_in  = (cyc % 4 == 0);
            if (pe_in) begin
                if (gen_en) begin
                    hs_in = (px < hs_w);
                    px = (px + 1 >= line_px) ? 0 : px + 1;
                end else begin
                    hs_in = 1'b0;
                    px = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic wait_toggle(input string name);
        logic t0;
        int   seen;
        t0 = line_toggle;
        seen = 0;
        for (int i = 0; i < 2000 && seen == 0; i++) begin
            @(posedge clk_sys);
            #1;
            if (line_toggle != t0) seen = 1;
        end
        chk({name, "_edge_seen"}, seen, 1);
    endtask

    initial begin
        // offsets in clks after the clk that registers an hsync rise
        tbl[0]  = '{0,   0,  99, 0, 0,  63, 0};
        tbl[1]  = '{1,   0,  99, 0, 0,  63, 0};
        tbl[2]  = '{2,   0,  0,  1, 0,  0,  1};
        tbl[3]  = '{4,   1,  1,  1, 1,  1,  1};
        tbl[4]  = '{8,   2,  3,  1, 2,  3,  1};
        tbl[5]  = '{10,  2,  4,  0, 2,  4,  0};
        tbl[6]  = '{200, 50, 99, 0, 50, 63, 0};
        tbl[7]  = '{202, 50, 0,  1, 50, 63, 0};
        tbl[8]  = '{208, 52, 3,  1, 52, 63, 0};
        tbl[9]  = '{210, 52, 4,  0, 52, 63, 0};
        tbl[10] = '{396, 99, 97, 0, 63, 63, 0};
        tbl[11] = '{398, 99, 98, 0, 63, 63, 0};

        // reset state
        reset = 1'b1;
        advance(3);
        chk("rst_hcnt", hcnt, 0);
        chk("rst_sd_hcnt", sd_hcnt, 0);
        chk("rst_toggle", line_toggle, 0);
        chk("rst_hs_sd", hs_sd, 0);
        chk("rst_locked", locked, 0);
        chk("rst_locked6", locked6, 0);
        reset = 1'b0;
        gen_en = 1;

        // lock sequence
        wait_toggle("r1");
        chk("r1_toggle", line_toggle, 1);
        chk("r1_locked", locked, 0);
        wait_toggle("r2");
        chk("r2_toggle", line_toggle, 0);
        chk("r2_locked", locked, 1);
        chk("r2_line_len", int'(u_dut.line_len), 100);
        wait_toggle("r3");
        chk("r3_toggle", line_toggle, 1);
        chk("r3_locked6", locked6, 1);

        // steady-state line replay, both buffer widths
        begin
            int cur;
            cur = 0;
            for (int i = 0; i < 12; i++) begin
                while (cur < tbl[i].off) begin
                    advance(1);
                    cur++;
                end
                chk($sformatf("v%0d_hcnt", i), hcnt, tbl[i].hcnt);
                chk($sformatf("v%0d_sd_hcnt", i), sd_hcnt, tbl[i].sd);
                chk($sformatf("v%0d_hs_sd", i), hs_sd, tbl[i].hs);
                chk($sformatf("v%0d_hcnt6", i), hcnt6, tbl[i].hcnt6);
                chk($sformatf("v%0d_sd_hcnt6", i), sd_hcnt6, tbl[i].sd6);
                chk($sformatf("v%0d_hs_sd6", i), hs_sd6, tbl[i].hs6);
            end
        end

        // hsync disappears: counter saturates, then lock is lost
        wait_toggle("r4");
        gen_en = 0;
        advance(16000);
        chk("to_still_locked", locked, 1);
        chk("to_hcnt_sat", hcnt, 1023);
        chk("to_hcnt6_sat", hcnt6, 63);
        advance(400);
        chk("to_locked", locked, 0);
        chk("to_sd_hcnt", sd_hcnt, 0);
        chk("to_hs_sd", hs_sd, 0);
        chk("to_sd_hcnt6", sd_hcnt6, 0);

        // re-lock after timeout
        gen_en = 1;
        wait_toggle("rl1");
        chk("rl1_locked", locked, 0);
        wait_toggle("rl2");
        chk("rl2_locked", locked, 1);

        // line length 100 -> 120
        line_px = 120;
        wait_toggle("ls1");
        chk("ls_sd_at_rise", sd_hcnt, 39);
        chk("ls_line_len", int'(u_dut.line_len), 120);
        advance(200);
        chk("ls_sd_99", sd_hcnt, 99);
        advance(2);
        chk("ls_no_wrap_99", sd_hcnt, 100);
        advance(38);
        chk("ls_sd_119", sd_hcnt, 119);
        advance(2);
        chk("ls_wrap_119", sd_hcnt, 0);
        chk("ls_wrap_hs", hs_sd, 1);
        advance(198);
        chk("ls_hcnt_110", hcnt, 110);
        chk("ls_hcnt6_110", hcnt6, 63);

        // reset mid-line at pixel 50
        wait_toggle("rm");
        advance(200);
        chk("rm_hcnt_50", hcnt, 50);
        chk("rm_sd_99", sd_hcnt, 99);
        reset = 1'b1;
        advance(1);
        chk("rm_hcnt", hcnt, 0);
        chk("rm_sd_hcnt", sd_hcnt, 0);
        chk("rm_toggle", line_toggle, 0);
        chk("rm_hs_sd", hs_sd, 0);
        chk("rm_locked", locked, 0);
        chk("rm_hcnt6", hcnt6, 0);
        reset = 1'b0;
        wait_toggle("rm1");
        chk("rm1_locked", locked, 0);
        chk("rm1_toggle", line_toggle, 1);
        wait_toggle("rm2");
        chk("rm2_locked", locked, 1);
        chk("rm2_toggle", line_toggle, 0);
        advance(2);
        chk("rm2_sd_restart", sd_hcnt, 0);
        chk("rm2_hs_sd", hs_sd, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
